prog_clock_divider: RTL and testbench

//  Multi-channel, run-time programmable clock divider and tick generator driven from the 40 MHz board clock.

---
 rtl/prog_clock_divider_pkg.sv | 16 +
 rtl/prog_clock_divider_channel.sv | 108 ++++++++++
 rtl/prog_clock_divider.sv | 43 ++++
 tb/tb_prog_clock_divider.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_clock_divider_pkg.sv
// Shared constants for the programmable clock divider: board clock, common ratios
// and the per-channel state encoding.
package prog_clock_divider_pkg;

  localparam int unsigned CLK_HZ    = 40_000_000;
  localparam int unsigned DIV_1HZ   = CLK_HZ;
  localparam int unsigned DIV_100HZ = CLK_HZ / 100;
  localparam int unsigned DIV_1KHZ  = CLK_HZ / 1_000;
  localparam int unsigned DIV_10KHZ = CLK_HZ / 10_000;

  typedef logic [0:0] ch_state_t;

  localparam ch_state_t ST_IDLE = 1'b0;
  localparam ch_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/prog_clock_divider_channel.sv
// One divider channel: counter, active and shadow ratio, pending flag and
// registered level/tick outputs. Ratio changes only land at cnt=0.
module div_channel
  import prog_clock_divider_pkg::*;
#(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = DIV_1HZ
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wdata,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  ch_state_t        state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] n_act, n_nxt;
  logic [DIV_W-1:0] shadow, shadow_nxt;
  logic             pend_nxt, clk_nxt, tick_nxt;
  logic [DIV_W-1:0] n_new, cnt_inc, half;
  logic             wrap;

  // A ratio of 1 cannot produce a level toggle, so it runs as 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] n);
    return (n == DIV_W'(1)) ? DIV_W'(2) : n;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      n_act   <= DIV_W'(DEFAULT_DIV);
      shadow  <= DIV_W'(DEFAULT_DIV);
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      n_act   <= n_nxt;
      shadow  <= shadow_nxt;
      pending <= pend_nxt;
      clk_out <= clk_nxt;
      tick    <= tick_nxt;
    end
  end

  // Ratio that holds after this edge if a pending shadow is applied now.
  assign n_new   = pending ? clamp_div(shadow) : n_act;
  assign cnt_inc = cnt + DIV_W'(1);
  assign half    = (n_act >> 1) + DIV_W'(n_act[0]);
  assign wrap    = (cnt == n_act - DIV_W'(1));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    n_nxt      = n_act;
    shadow_nxt = shadow;
    pend_nxt   = pending;
    clk_nxt    = 1'b0;
    tick_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (pending) begin
          n_nxt    = n_new;
          pend_nxt = 1'b0;
        end
        if (en && (n_new != '0)) begin
          state_nxt = ST_RUN;
          clk_nxt   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (wrap) begin
          cnt_nxt = '0;
          if (pending) begin
            n_nxt    = n_new;
            pend_nxt = 1'b0;
          end
          if (n_new == '0) state_nxt = ST_IDLE;
          else             clk_nxt   = 1'b1;
        end else begin
          cnt_nxt  = cnt_inc;
          clk_nxt  = (cnt_inc < half);
          tick_nxt = (cnt_inc == n_act - DIV_W'(1));
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // A write lands after any application on this edge, so it waits for the next one.
    if (wr) begin
      shadow_nxt = wdata;
      pend_nxt   = 1'b1;
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel run-time programmable clock divider / tick generator.
// Decodes the config write to one channel and instantiates NUM_CH dividers.
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = DIV_1HZ,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel numbers match no instance and are dropped.
    assign wr[i] = cfg_we && (cfg_ch == CH_W'(i));

    div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (ch_en[i]),
      .wr      (wr[i]),
      .wdata   (cfg_div),
      .pending (cfg_pending[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench: the driver queues hand-computed per-edge outputs, a monitor
// pops and compares one entry after each clock edge.
`timescale 1ns/1ps
module tb_prog_clock_divider;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CH_W   = 2;

  logic              clk_in = 1'b0;
  logic              rst_n  = 1'b0;
  logic [NUM_CH-1:0] ch_en  = '0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [NUM_CH-1:0] cfg_pending, clk_out, tick;

  prog_clock_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .ch_en       (ch_en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_pending (cfg_pending),
    .clk_out     (clk_out),
    .tick        (tick)
  );

  always #12.5 clk_in = ~clk_in;

  typedef struct packed {
    logic [2:0] c;
    logic [2:0] t;
    logic [2:0] p;
    int         phase;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   phase = 0;

  function automatic void cmp(input string tag, input int ph,
                              input logic [8:0] got, input logic [8:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s phase%0d: got clk_out/tick/pending=%b/%b/%b required %b/%b/%b",
               tag, ph, got[8:6], got[5:3], got[2:0], want[8:6], want[5:3], want[2:0]);
    end
  endfunction

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic cyc(input logic [2:0] en, input logic we, input logic [1:0] ch,
                     input logic [7:0] div, input logic [2:0] ec, input logic [2:0] et,
                     input logic [2:0] ep);
    exp_t e;
    @(negedge clk_in);
    ch_en   = en;
    cfg_we  = we;
    cfg_ch  = ch;
    cfg_div = div;
    e.c = ec; e.t = et; e.p = ep; e.phase = phase;
    q.push_back(e);
  endtask

  task automatic idle(input logic [2:0] en, input logic [2:0] ec, input logic [2:0] et,
                      input logic [2:0] ep);
    cyc(en, 1'b0, 2'd0, 8'd0, ec, et, ep);
  endtask

  // Monitor: one queued expectation per rising edge while any are outstanding.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("edge", e.phase, {clk_out, tick, cfg_pending}, {e.c, e.t, e.p});
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: bench did not finish, got time %0t required < 200us", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk_in);
    cmp("reset", 0, {clk_out, tick, cfg_pending}, 9'b0);
    rst_n = 1'b1;

    // Phase 1: default N=4 on ch0, pattern 1100, tick every 4th
    phase = 1;
    repeat (2) begin
      idle(3'b001, 3'b001, 3'b000, 3'b000);
      idle(3'b001, 3'b001, 3'b000, 3'b000);
      idle(3'b001, 3'b000, 3'b000, 3'b000);
      idle(3'b001, 3'b000, 3'b001, 3'b000);
    end

    // Phase 2: N=5 written at cnt=1, lands at the next wrap
    phase = 2;
    idle(3'b001, 3'b001, 3'b000, 3'b000);
    idle(3'b001, 3'b001, 3'b000, 3'b000);
    cyc (3'b001, 1'b1, 2'd0, 8'd5, 3'b000, 3'b000, 3'b001);
    idle(3'b001, 3'b000, 3'b001, 3'b001);
    repeat (2) begin
      idle(3'b001, 3'b001, 3'b000, 3'b000);
      idle(3'b001, 3'b001, 3'b000, 3'b000);
      idle(3'b001, 3'b001, 3'b000, 3'b000);
      idle(3'b001, 3'b000, 3'b000, 3'b000);
      idle(3'b001, 3'b000, 3'b001, 3'b000);
    end

    // Phase 3: N=3 written on the wrap edge, one more N=5 period first
    phase = 3;
    cyc (3'b001, 1'b1, 2'd0, 8'd3, 3'b001, 3'b000, 3'b001);
    idle(3'b001, 3'b001, 3'b000, 3'b001);
    idle(3'b001, 3'b001, 3'b000, 3'b001);
    idle(3'b001, 3'b000, 3'b000, 3'b001);
    idle(3'b001, 3'b000, 3'b001, 3'b001);
    repeat (2) begin
      idle(3'b001, 3'b001, 3'b000, 3'b000);
      idle(3'b001, 3'b001, 3'b000, 3'b000);
      idle(3'b001, 3'b000, 3'b001, 3'b000);
    end

    // Phase 4: N=0 stops after the period, N=1 runs as 2, cfg_ch=3 ignored
    phase = 4;
    idle(3'b001, 3'b001, 3'b000, 3'b000);
    cyc (3'b001, 1'b1, 2'd0, 8'd0, 3'b001, 3'b000, 3'b001);
    idle(3'b001, 3'b000, 3'b001, 3'b001);
    idle(3'b001, 3'b000, 3'b000, 3'b000);
    idle(3'b001, 3'b000, 3'b000, 3'b000);
    idle(3'b001, 3'b000, 3'b000, 3'b000);
    cyc (3'b001, 1'b1, 2'd0, 8'd1, 3'b000, 3'b000, 3'b001);
    idle(3'b001, 3'b001, 3'b000, 3'b000);
    idle(3'b001, 3'b000, 3'b001, 3'b000);
    idle(3'b001, 3'b001, 3'b000, 3'b000);
    idle(3'b001, 3'b000, 3'b001, 3'b000);
    cyc (3'b001, 1'b1, 2'd3, 8'd7, 3'b001, 3'b000, 3'b000);
    idle(3'b001, 3'b000, 3'b001, 3'b000);

    // Phase 5: disable mid-period, write while idle, async reset mid-period
    phase = 5;
    cyc (3'b001, 1'b1, 2'd0, 8'd6, 3'b001, 3'b000, 3'b001);
    idle(3'b001, 3'b000, 3'b001, 3'b001);
    idle(3'b001, 3'b001, 3'b000, 3'b000);
    idle(3'b001, 3'b001, 3'b000, 3'b000);
    idle(3'b001, 3'b001, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000, 3'b000);
    idle(3'b000, 3'b000, 3'b000, 3'b000);
    cyc (3'b000, 1'b1, 2'd0, 8'd4, 3'b000, 3'b000, 3'b001);
    idle(3'b000, 3'b000, 3'b000, 3'b000);
    idle(3'b001, 3'b001, 3'b000, 3'b000);
    cyc (3'b001, 1'b1, 2'd1, 8'd9, 3'b001, 3'b000, 3'b010);
    @(negedge clk_in);
    rst_n  = 1'b0;
    ch_en  = '0;
    cfg_we = 1'b0;
    #1;
    cmp("async_reset", 5, {clk_out, tick, cfg_pending}, 9'b0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;

    // Phase 6: two channels; ch1 rewritten to N=2 while ch0 wraps
    phase = 6;
    idle(3'b011, 3'b011, 3'b000, 3'b000);
    idle(3'b011, 3'b011, 3'b000, 3'b000);
    idle(3'b011, 3'b000, 3'b000, 3'b000);
    idle(3'b011, 3'b000, 3'b011, 3'b000);
    cyc (3'b011, 1'b1, 2'd1, 8'd2, 3'b011, 3'b000, 3'b010);
    idle(3'b011, 3'b011, 3'b000, 3'b010);
    idle(3'b011, 3'b000, 3'b000, 3'b010);
    idle(3'b011, 3'b000, 3'b011, 3'b010);
    idle(3'b011, 3'b011, 3'b000, 3'b000);
    idle(3'b011, 3'b001, 3'b010, 3'b000);
    idle(3'b011, 3'b010, 3'b000, 3'b000);
    idle(3'b011, 3'b000, 3'b011, 3'b000);
    idle(3'b011, 3'b011, 3'b000, 3'b000);

    // Phase 7: maximum ratio 255 on ch2: 128 high, 127 low, tick at cnt=254
    phase = 7;
    cyc (3'b000, 1'b1, 2'd2, 8'd255, 3'b000, 3'b000, 3'b100);
    for (int k = 0; k < 258; k++) begin
      idle(3'b100, ((k % 255) < 128) ? 3'b100 : 3'b000,
           ((k % 255) == 254) ? 3'b100 : 3'b000, 3'b000);
    end

    @(posedge clk_in);
    #5;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
